// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for cmd_seq_player and its benches.
package seq_pkg;

    // Playback FSM states.
    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        FAIL
    } seq_state_t;

    // Reason the last playback stopped early.
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        NACK    = 2'd1,
        TIMEOUT = 2'd2
    } fail_code_t;

    // Positive acknowledge byte returned by the Knight.
    localparam logic [7:0] POS_ACK = 8'hA5;

    // Knight command opcodes (upper nibble selects the command).
    localparam logic [15:0] CAL_GYRO  = 16'h2000;
    localparam logic [15:0] MOVE_CMD  = 16'h4000;
    localparam logic [15:0] MOVE_FANF = 16'h5000;

endpackage

// File: rtl/cmd_seq_player_if.sv
// cmd_seq_player_if: command/response handshake between the player and RemoteComm.
interface cmd_seq_player_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    // Player side drives the command, RemoteComm returns completion and response.
    modport master (output cmd, output snd_cmd, input cmd_snt, input resp_rdy, input resp);
    modport slave  (input cmd, input snd_cmd, output cmd_snt, output resp_rdy, output resp);
endinterface

// File: rtl/resp_timer.sv
// resp_timer: saturating response timer; expire flags the last allowed cycle.
module resp_timer #(
    parameter int TO_CLKS = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int TW = $clog2(TO_CLKS) + 1;
    localparam logic [TW-1:0] LAST = TW'(TO_CLKS - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        // NOTE: cnt_d gets a default before any branch so no path can infer a latch.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values together.
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = enable && (cnt_q == LAST);
endmodule

// File: rtl/cmd_seq_player.sv
// cmd_seq_player: replays a loaded script of Knight commands through RemoteComm,
// checking each ack, timing out silent responses and retrying a bounded number of times.
// Optional SEQ_LOOP_EN: replay the script forever, counting wraps on loop_cnt.
module cmd_seq_player
    import seq_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         TO_CLKS   = 1_000_000,
    parameter int         MAX_RETRY = 2,
    parameter logic [7:0] ACK_VAL   = POS_ACK,
    localparam int        AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [AW:0]       num_cmds,
    input  logic              start,
    input  logic              abort,
    cmd_seq_player_if.master  rc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        fail_code,
    output logic [AW-1:0]     cmd_idx
`ifdef SEQ_LOOP_EN
    ,
    output logic [15:0]       loop_cnt
`endif
);
    seq_state_t    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic [2:0]    retry_q, retry_d;
    logic          err_q, err_d;
    fail_code_t    fc_q, fc_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          done_q, done_d;
    logic          ev_valid;
    fail_code_t    ev_code;
    logic          tmr_clear, tmr_en, tmr_expire;
    logic [15:0]   mem_q [DEPTH];
`ifdef SEQ_LOOP_EN
    logic [15:0]   loop_q, loop_d;
`endif

    // Script memory write port, open only while idle.
    always_ff @(posedge clk) begin
        // NOTE: the script RAM is intentionally not reset so a loaded script survives rst_n.
        if (wr_en && (state_q == IDLE)) mem_q[wr_addr] <= wr_data;
    end

    // The timer runs only while a response is awaited and is zero on entry.
    assign tmr_clear = (state_q != WAIT_RESP);
    assign tmr_en    = (state_q == WAIT_RESP);

    resp_timer #(.TO_CLKS(TO_CLKS)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expire (tmr_expire)
    );

    // Next-state and datapath updates; abort overrides every event outside IDLE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        retry_d  = retry_q;
        err_d    = err_q;
        fc_d     = fc_q;
        cmd_d    = cmd_q;
        done_d   = 1'b0;
        ev_valid = 1'b0;
        ev_code  = NONE;
`ifdef SEQ_LOOP_EN
        loop_d   = loop_q;
`endif
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d   = num_cmds;
                        err_d   = 1'b0;
                        fc_d    = NONE;
                        idx_d   = '0;
                        retry_d = '0;
`ifdef SEQ_LOOP_EN
                        loop_d  = '0;
`endif
                        if (num_cmds == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = SEND;
                            cmd_d   = mem_q[0];
                        end
                    end
                end
                SEND:     state_d = WAIT_SNT;
                WAIT_SNT: if (rc.cmd_snt) state_d = WAIT_RESP;
                WAIT_RESP: begin
                    if (rc.resp_rdy) begin
                        if (rc.resp == ACK_VAL) begin
                            retry_d = '0;
                            if ({1'b0, idx_q} == (len_q - 1'b1)) begin
                                done_d = 1'b1;
`ifdef SEQ_LOOP_EN
                                idx_d   = '0;
                                state_d = SEND;
                                cmd_d   = mem_q[0];
                                if (loop_q != '1) loop_d = loop_q + 1'b1;
`else
                                state_d = IDLE;
`endif
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                state_d = SEND;
                                cmd_d   = mem_q[idx_q + 1'b1];
                            end
                        end else begin
                            ev_valid = 1'b1;
                            ev_code  = NACK;
                        end
                    end else if (tmr_expire) begin
                        ev_valid = 1'b1;
                        ev_code  = TIMEOUT;
                    end
                    if (ev_valid) begin
                        if (retry_q < 3'(MAX_RETRY)) begin
                            retry_d = retry_q + 1'b1;
                            state_d = SEND;
                            cmd_d   = mem_q[idx_q];
                        end else begin
                            state_d = FAIL;
                            err_d   = 1'b1;
                            fc_d    = ev_code;
                        end
                    end
                end
                FAIL:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
            fc_q    <= NONE;
            cmd_q   <= '0;
            done_q  <= 1'b0;
`ifdef SEQ_LOOP_EN
            loop_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            retry_q <= retry_d;
            err_q   <= err_d;
            fc_q    <= fc_d;
            cmd_q   <= cmd_d;
            done_q  <= done_d;
`ifdef SEQ_LOOP_EN
            loop_q  <= loop_d;
`endif
        end
    end

    assign rc.cmd     = cmd_q;
    assign rc.snd_cmd = (state_q == SEND) && !abort;
    assign busy       = (state_q == SEND) || (state_q == WAIT_SNT) || (state_q == WAIT_RESP);
    assign done       = done_q;
    assign err        = err_q;
    assign fail_code  = fc_q;
    assign cmd_idx    = idx_q;
`ifdef SEQ_LOOP_EN
    assign loop_cnt   = loop_q;
`endif
endmodule
